mask_gen_param: RTL

//  Parametrised row-mask generator (successor to the fixed 640x480 VGA mask generator). Produces one ROW_W-bit mask per row, N_ROWS rows per frame.

---
 rtl/mask_gen_param.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mask_gen_param.sv
// rtl/mask_gen_param.sv - parametrised row-mask generator with slide, LFSR and tile modes
module mask_gen_param #(
    parameter int                ROW_W     = 640,
    parameter int                N_ROWS    = 480,
    parameter int                PAT_MAX   = 32,
    parameter int                RP_W      = 8,
    parameter int                LFSR_W    = 32,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 32'hA3000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic                       load_pattern,
    input  logic                       pattern,
    input  logic [$clog2(PAT_MAX)-1:0] pat_len_m1,
    input  logic [RP_W-1:0]            rep_pattern,
    input  logic [1:0]                 mask_type,
    input  logic                       gen_en,
    input  logic                       mask_ready,
    output logic                       mask_valid,
    output logic [0:ROW_W-1]           mask,
    output logic [$clog2(N_ROWS)-1:0]  row_idx,
    output logic                       frame_last,
    output logic                       busy
);

    localparam int PLW = $clog2(PAT_MAX);
    localparam int CW  = $clog2(PAT_MAX + 1);
    localparam int RIW = $clog2(N_ROWS);
    localparam logic [RIW-1:0] LAST_ROW = RIW'(N_ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PREP, S_RUN} state_t;

    state_t             state_q;
    logic [0:PAT_MAX-1] pat_q;
    logic [CW-1:0]      ld_cnt_q;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [0:ROW_W-1]   mask_q;
    logic [RIW-1:0]     row_idx_q;
    logic               valid_q;
    logic [1:0]         mode_q;
    logic [PLW:0]       len_q;

    logic [PLW:0]       len_in_d;
    logic [LFSR_W-1:0]  seed_d;
    logic [LFSR_W-1:0]  lfsr_nxt_d;
    logic [0:ROW_W-1]   row0_in_d;
    logic [0:ROW_W-1]   row0_run_d;
    logic               hs_d;
    logic               last_d;

    function automatic logic [0:ROW_W-1] build_row0(input logic [0:PAT_MAX-1] p,
                                                    input logic [PLW:0] len);
        logic [0:ROW_W-1] m;
        m = '0;
        for (int i = 0; i < PAT_MAX; i++)
            if (i < int'(len)) m[i] = p[i];
        return m;
    endfunction

    // Pattern bit j lands at the LFSR MSB side so the seed reads left-to-right like the mask.
    function automatic logic [LFSR_W-1:0] build_seed(input logic [0:PAT_MAX-1] p,
                                                     input logic [PLW:0] len);
        logic [LFSR_W-1:0] s;
        s = '0;
        for (int j = 0; j < LFSR_W; j++)
            if (j < int'(len)) s[LFSR_W-1-j] = p[j];
        if (s == '0) s = LFSR_W'(1);
        return s;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        logic [LFSR_W-1:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ LFSR_TAPS;
        return n;
    endfunction

    function automatic logic [0:ROW_W-1] tile_lfsr(input logic [LFSR_W-1:0] l);
        logic [0:ROW_W-1] m;
        for (int i = 0; i < ROW_W; i++) m[i] = l[LFSR_W-1-(i % LFSR_W)];
        return m;
    endfunction

    function automatic logic [0:ROW_W-1] tile_rep(input logic [RP_W-1:0] r);
        logic [0:ROW_W-1] m;
        for (int i = 0; i < ROW_W; i++) m[i] = r[RP_W-1-(i % RP_W)];
        return m;
    endfunction

    assign len_in_d   = {1'b0, pat_len_m1} + (PLW+1)'(1);
    assign seed_d     = build_seed(pat_q, len_in_d);
    assign lfsr_nxt_d = lfsr_step(lfsr_q);
    assign row0_in_d  = build_row0(pat_q, len_in_d);
    assign row0_run_d = build_row0(pat_q, len_q);
    assign hs_d       = valid_q & mask_ready;
    assign last_d     = (row_idx_q == LAST_ROW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            ld_cnt_q  <= '0;
            lfsr_q    <= '0;
            mask_q    <= '0;
            row_idx_q <= '0;
            valid_q   <= 1'b0;
            mode_q    <= 2'b00;
            len_q     <= '0;
        end else if (clk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (load_pattern) begin
                        pat_q    <= {pattern, {(PAT_MAX-1){1'b0}}};
                        ld_cnt_q <= CW'(1);
                        state_q  <= S_LOAD;
                    end else if (gen_en) begin
                        state_q <= S_PREP;
                    end
                end
                S_LOAD: begin
                    if (load_pattern) begin
                        if (ld_cnt_q < CW'(PAT_MAX)) begin
                            pat_q[ld_cnt_q[PLW-1:0]] <= pattern;
                            ld_cnt_q                 <= ld_cnt_q + CW'(1);
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_PREP: begin
                    mode_q    <= mask_type;
                    len_q     <= len_in_d;
                    lfsr_q    <= seed_d;
                    row_idx_q <= '0;
                    valid_q   <= 1'b1;
                    state_q   <= S_RUN;
                    case (mask_type)
                        2'b10:   mask_q <= tile_lfsr(seed_d);
                        2'b11:   mask_q <= tile_rep(rep_pattern);
                        default: mask_q <= row0_in_d;
                    endcase
                end
                S_RUN: begin
                    if (hs_d) begin
                        if (last_d && !gen_en) begin
                            valid_q <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            row_idx_q <= last_d ? '0 : row_idx_q + RIW'(1);
                            // Tile rows are all identical, so mode 11 simply holds the mask.
                            case (mode_q)
                                2'b00: mask_q <= last_d ? row0_run_d
                                                        : {mask_q[ROW_W-1], mask_q[0:ROW_W-2]};
                                2'b01: mask_q <= last_d ? row0_run_d
                                                        : {mask_q[1:ROW_W-1], mask_q[0]};
                                2'b10: begin
                                    lfsr_q <= lfsr_nxt_d;
                                    mask_q <= tile_lfsr(lfsr_nxt_d);
                                end
                                default: mask_q <= mask_q;
                            endcase
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mask_valid = valid_q;
    assign mask       = mask_q;
    assign row_idx    = row_idx_q;
    assign frame_last = valid_q & last_d;
    assign busy       = (state_q != S_IDLE);

endmodule
